dbg_regscan_sched: RTL and testbench

- Frame-synchronous scheduler that copies the CPU register file into a double-buffered shadow RAM used by the VGA debug text overlay.
- It shares the register file's single debug read port with the CPU-side debug arbiter through a req/gnt handshake.
- It scans all registers during vertical blanking, then swaps the display bank, so the overlay never shows a torn, half-updated register set.

---
 rtl/dbg_regscan_sched.sv | 166 ++++++++++++++++
 tb/tb_dbg_regscan_sched.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/dbg_regscan_sched.sv
// Copies the register file into a double-buffered shadow RAM once per frame, then swaps banks.
// Optional: DBG_REGSCAN_X0_CONST_EN writes index 0 as constant zero and skips its port read.
module dbg_regscan_sched #(
  parameter int NUM_REGS    = 32,
  parameter int ADDR_W      = 5,
  parameter int DATA_W      = 32,
  parameter int READ_LAT    = 1,
  parameter int GNT_TIMEOUT = 255
) (
  input  logic              clock,
  input  logic              rst,
  input  logic              frame_start,
  input  logic              freeze,
  output logic              dbg_req,
  input  logic              dbg_gnt,
  output logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_rdata,
  output logic              shadow_we,
  output logic [ADDR_W:0]   shadow_waddr,
  output logic [DATA_W-1:0] shadow_wdata,
  output logic              disp_bank,
  output logic              scan_busy,
  output logic              scan_done,
  output logic              overrun,
  output logic              timeout
);

  localparam int WAIT_W  = $clog2(GNT_TIMEOUT + 1);
  localparam int DRAIN_W = $clog2(READ_LAT + 1);
  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NUM_REGS - 1);

  typedef enum logic [2:0] {IDLE, REQ, READ, DRAIN, SWAP} state_t;

  state_t                             state_reg, state_next;
  logic [WAIT_W-1:0]                  wait_cnt_reg, wait_cnt_next;
  logic [ADDR_W:0]                    addr_reg, addr_next;
  logic [DRAIN_W-1:0]                 drain_cnt_reg, drain_cnt_next;
  logic                               disp_bank_reg, overrun_reg, timeout_reg;
  logic [READ_LAT-1:0]                pipe_valid_reg, pipe_valid_next;
  logic [READ_LAT-1:0][ADDR_W-1:0]    pipe_idx_reg, pipe_idx_next;
  logic                               issue, timeout_set, swap, x0_we, pipe_out_valid;
  logic [ADDR_W:0]                    first_idx;

`ifdef DBG_REGSCAN_X0_CONST_EN
  logic first_rd_reg;

  // Index 0 is written as zero during the first READ cycle, without touching the port.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) first_rd_reg <= 1'b0;
    else     first_rd_reg <= (state_reg == REQ) && (state_next == READ);
  end

  assign x0_we     = first_rd_reg;
  assign first_idx = (ADDR_W+1)'(1);
`else
  assign x0_we     = 1'b0;
  assign first_idx = '0;
`endif

  // Tag pipeline: marks which index the read data belongs to when it arrives.
  genvar gi;
  generate
    for (gi = 0; gi < READ_LAT; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        assign pipe_valid_next[gi] = issue;
        assign pipe_idx_next[gi]   = addr_reg[ADDR_W-1:0];
      end else begin : g_tail
        assign pipe_valid_next[gi] = pipe_valid_reg[gi-1];
        assign pipe_idx_next[gi]   = pipe_idx_reg[gi-1];
      end
    end
  endgenerate

  always_comb begin
    state_next     = state_reg;
    wait_cnt_next  = wait_cnt_reg;
    addr_next      = addr_reg;
    drain_cnt_next = drain_cnt_reg;
    dbg_req        = 1'b0;
    issue          = 1'b0;
    timeout_set    = 1'b0;
    swap           = 1'b0;
    case (state_reg)
      IDLE: begin
        if (frame_start && !freeze) begin
          state_next    = REQ;
          wait_cnt_next = '0;
        end
      end
      REQ: begin
        dbg_req = 1'b1;
        if (dbg_gnt) begin
          state_next = READ;
          addr_next  = first_idx;
        end else if (wait_cnt_reg == WAIT_W'(GNT_TIMEOUT - 1)) begin
          state_next  = IDLE;
          timeout_set = 1'b1;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      READ: begin
        dbg_req = 1'b1;
        if (dbg_gnt) begin
          issue     = 1'b1;
          addr_next = addr_reg + 1'b1;
          if (addr_reg == LAST_IDX) begin
            state_next     = DRAIN;
            drain_cnt_next = '0;
          end
        end
      end
      DRAIN: begin
        // Swap only once the last tag has left the pipeline.
        if (drain_cnt_reg == DRAIN_W'(READ_LAT) && pipe_valid_reg == '0) begin
          state_next = SWAP;
          swap       = 1'b1;
        end else if (drain_cnt_reg != DRAIN_W'(READ_LAT)) begin
          drain_cnt_next = drain_cnt_reg + 1'b1;
        end
      end
      SWAP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      wait_cnt_reg   <= '0;
      addr_reg       <= '0;
      drain_cnt_reg  <= '0;
      disp_bank_reg  <= 1'b0;
      overrun_reg    <= 1'b0;
      timeout_reg    <= 1'b0;
      pipe_valid_reg <= '0;
      pipe_idx_reg   <= '0;
    end else begin
      state_reg      <= state_next;
      wait_cnt_reg   <= wait_cnt_next;
      addr_reg       <= addr_next;
      drain_cnt_reg  <= drain_cnt_next;
      pipe_valid_reg <= pipe_valid_next;
      pipe_idx_reg   <= pipe_idx_next;
      if (swap)
        disp_bank_reg <= ~disp_bank_reg;
      if (frame_start && state_reg != IDLE)
        overrun_reg <= 1'b1;
      if (timeout_set)
        timeout_reg <= 1'b1;
    end
  end

  assign pipe_out_valid = pipe_valid_reg[READ_LAT-1];
  assign dbg_addr       = addr_reg[ADDR_W-1:0];
  assign shadow_we      = pipe_out_valid | x0_we;
  assign shadow_waddr   = pipe_out_valid ? {~disp_bank_reg, pipe_idx_reg[READ_LAT-1]} :
                          x0_we          ? {~disp_bank_reg, {ADDR_W{1'b0}}} : '0;
  assign shadow_wdata   = pipe_out_valid ? dbg_rdata : '0;
  assign disp_bank      = disp_bank_reg;
  assign scan_busy      = (state_reg != IDLE);
  assign scan_done      = (state_reg == SWAP);
  assign overrun        = overrun_reg;
  assign timeout        = timeout_reg;

endmodule

// File: tb/tb_dbg_regscan_sched.sv
// Directed bench for dbg_regscan_sched: register-file model, shadow-write monitor, per-frame checks.
module tb_dbg_regscan_sched;

  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int READ_LAT = 1;
`ifdef DBG_REGSCAN_X0_CONST_EN
  localparam int EXP_LAT = NUM_REGS + READ_LAT + 1;
  localparam bit X0      = 1'b1;
`else
  localparam int EXP_LAT = NUM_REGS + READ_LAT + 2;
  localparam bit X0      = 1'b0;
`endif

  logic              clock = 1'b0;
  logic              rst, frame_start, freeze, dbg_gnt;
  logic              dbg_req, shadow_we, disp_bank, scan_busy, scan_done, overrun, timeout;
  logic [ADDR_W-1:0] dbg_addr;
  logic [DATA_W-1:0] dbg_rdata = '0;
  logic [ADDR_W:0]   shadow_waddr;
  logic [DATA_W-1:0] shadow_wdata;
  logic [31:0]       rf_base = '0;

  int n_vec = 0, n_err = 0;
  int cyc_cnt = 0, wr_cnt, done_cnt, done_at, req_cnt, last_issue, lat;
  int hits [64];
  logic [31:0] wdat [64];

  dbg_regscan_sched #(
    .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W), .DATA_W(DATA_W),
    .READ_LAT(READ_LAT), .GNT_TIMEOUT(255)
  ) dut (
    .clock(clock), .rst(rst), .frame_start(frame_start), .freeze(freeze),
    .dbg_req(dbg_req), .dbg_gnt(dbg_gnt), .dbg_addr(dbg_addr), .dbg_rdata(dbg_rdata),
    .shadow_we(shadow_we), .shadow_waddr(shadow_waddr), .shadow_wdata(shadow_wdata),
    .disp_bank(disp_bank), .scan_busy(scan_busy), .scan_done(scan_done),
    .overrun(overrun), .timeout(timeout)
  );

  always #5 clock = ~clock;

  // Register file: register i holds rf_base + i, one cycle read latency.
  always @(posedge clock) dbg_rdata <= rf_base + 32'(dbg_addr);

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    wr_cnt = 0; done_cnt = 0; done_at = 0; req_cnt = 0; last_issue = -1;
    for (int i = 0; i < 64; i++) begin
      hits[i] = 0;
      wdat[i] = '0;
    end
  endtask

  // Sample the current cycle at the falling edge, then step just past the next rising edge.
  task automatic tick();
    @(negedge clock);
    cyc_cnt++;
    if (shadow_we) begin
      wr_cnt++;
      hits[shadow_waddr]++;
      wdat[shadow_waddr] = shadow_wdata;
    end
    if (scan_done) begin
      done_cnt++;
      done_at = cyc_cnt;
    end
    if (dbg_req) req_cnt++;
    if (dbg_req && dbg_gnt) last_issue = int'(dbg_addr);
    @(posedge clock);
    #1;
  endtask

  task automatic run_frame(input logic [31:0] base, input int drop_len, input int extra_fs_at,
                           output int latency);
    int t0, drop_left;
    bit dropped;
    clear_mon();
    rf_base = base;
    drop_left = 0;
    dropped = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    t0 = cyc_cnt;
    for (int c = 0; c < 400 && done_cnt == 0; c++) begin
      frame_start = (c == extra_fs_at);
      tick();
      if (drop_left > 0) begin
        drop_left--;
        if (drop_left == 0) dbg_gnt = 1'b1;
      end else if (drop_len > 0 && !dropped && last_issue == 10) begin
        dbg_gnt = 1'b0;
        drop_left = drop_len;
        dropped = 1'b1;
      end
    end
    frame_start = 1'b0;
    dbg_gnt = 1'b1;
    latency = (done_cnt > 0) ? (done_at - t0 - 1) : -1;
    repeat (5) tick();
    $display("frame base=%h writes=%0d swaps=%0d latency=%0d", base, wr_cnt, done_cnt, latency);
  endtask

  task automatic check_scan(input string tag, input int bank, input logic [31:0] base,
                            input int exp_lat, input int latency);
    logic [31:0] exp_d;
    check({tag, "_writes"}, 64'(wr_cnt), 64'(NUM_REGS));
    check({tag, "_swaps"}, 64'(done_cnt), 64'd1);
    check({tag, "_latency"}, 64'(latency), 64'(exp_lat));
    for (int i = 0; i < NUM_REGS; i++) begin
      exp_d = (X0 && i == 0) ? 32'h0 : base + 32'(i);
      check($sformatf("%s_hits%0d", tag, i), 64'(hits[bank*32 + i]), 64'd1);
      check($sformatf("%s_data%0d", tag, i), 64'(wdat[bank*32 + i]), 64'(exp_d));
    end
  endtask

  initial begin
    rst = 1'b1; frame_start = 1'b0; freeze = 1'b0; dbg_gnt = 1'b1;
    clear_mon();
    repeat (3) @(posedge clock);
    #1;
    check("rst_req", 64'(dbg_req), 64'd0);
    check("rst_we", 64'(shadow_we), 64'd0);
    check("rst_bank", 64'(disp_bank), 64'd0);
    check("rst_busy", 64'(scan_busy), 64'd0);
    check("rst_done", 64'(scan_done), 64'd0);
    check("rst_flags", 64'({overrun, timeout}), 64'd0);
    check("rst_addr", 64'(dbg_addr), 64'd0);
    check("rst_waddr", 64'(shadow_waddr), 64'd0);
    rst = 1'b0;
    tick();

    // Grant held high: full scan into bank 1.
    run_frame(32'h1000_0000, 0, -1, lat);
    check_scan("basic", 1, 32'h1000_0000, EXP_LAT, lat);
    check("basic_bank", 64'(disp_bank), 64'd1);
    check("basic_busy", 64'(scan_busy), 64'd0);

    // Grant dropped for 5 cycles after index 10.
    run_frame(32'h2000_0000, 5, -1, lat);
    check_scan("gntdrop", 0, 32'h2000_0000, EXP_LAT + 5, lat);
    check("gntdrop_bank", 64'(disp_bank), 64'd0);

    // Grant never given: timeout after 255 request cycles.
    clear_mon();
    dbg_gnt = 1'b0;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    repeat (256) tick();
    check("to_flag", 64'(timeout), 64'd1);
    check("to_writes", 64'(wr_cnt), 64'd0);
    check("to_bank", 64'(disp_bank), 64'd0);
    check("to_busy", 64'(scan_busy), 64'd0);
    check("to_req", 64'(dbg_req), 64'd0);
    check("to_reqcycles", 64'(req_cnt), 64'd255);
    check("to_swaps", 64'(done_cnt), 64'd0);
    check("to_overrun", 64'(overrun), 64'd0);
    dbg_gnt = 1'b1;

    // Freeze rising with frame_start, three frames ignored.
    clear_mon();
    freeze = 1'b1;
    for (int f = 0; f < 3; f++) begin
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      repeat (40) tick();
    end
    check("frz_req", 64'(req_cnt), 64'd0);
    check("frz_writes", 64'(wr_cnt), 64'd0);
    check("frz_bank", 64'(disp_bank), 64'd0);
    check("frz_overrun", 64'(overrun), 64'd0);
    freeze = 1'b0;
    run_frame(32'h4000_0000, 0, -1, lat);
    check_scan("unfrz", 1, 32'h4000_0000, EXP_LAT, lat);
    check("unfrz_bank", 64'(disp_bank), 64'd1);

    // Second frame_start mid-scan: overrun, exactly one swap.
    run_frame(32'h3000_0000, 0, 10, lat);
    repeat (60) tick();
    check_scan("ovr", 0, 32'h3000_0000, EXP_LAT, lat);
    check("ovr_flag", 64'(overrun), 64'd1);
    check("ovr_bank", 64'(disp_bank), 64'd0);
    check("ovr_busy", 64'(scan_busy), 64'd0);

    // Reset right after index 15 is issued: outputs clear before the next edge.
    clear_mon();
    rf_base = 32'h5000_0000;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    for (int c = 0; c < 100 && last_issue != 15; c++) tick();
    check("mid_reach15", 64'(last_issue), 64'd15);
    rst = 1'b1;
    #1;
    check("mid_req", 64'(dbg_req), 64'd0);
    check("mid_busy", 64'(scan_busy), 64'd0);
    check("mid_we", 64'(shadow_we), 64'd0);
    check("mid_wdata", 64'(shadow_wdata), 64'd0);
    check("mid_addr", 64'(dbg_addr), 64'd0);
    check("mid_flags", 64'({overrun, timeout}), 64'd0);
    check("mid_bank", 64'(disp_bank), 64'd0);
    repeat (2) @(posedge clock);
    #1;
    rst = 1'b0;
    tick();
    run_frame(32'h6000_0000, 0, -1, lat);
    check_scan("postrst", 1, 32'h6000_0000, EXP_LAT, lat);
    check("postrst_bank", 64'(disp_bank), 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
